// File: rtl/fcmp_pipe.sv
// Pipelined IEEE-754 compare / branch-resolve unit: classify both operands, then resolve
// the requested predicate with IEEE unordered semantics. Depth is 1 or 2 register stages.
module fcmp_pipe #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_op,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_res,
  output logic                   out_unord,
  output logic [TAG_W-1:0]       out_tag
);

  localparam int W = 1 + EXP_W + MAN_W;

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // valid never waits on ready, and a held result keeps its payload until it transfers.

  logic [EXP_W-1:0] w_exp_a, w_exp_b;
  logic [MAN_W-1:0] w_man_a, w_man_b;
  logic             w_nan_a, w_nan_b, w_zero_a, w_zero_b;
  logic             w_c_unord, w_c_eq_raw, w_c_mag_lt, w_c_sa, w_c_sb;

  assign w_exp_a    = in_a[W-2:MAN_W];
  assign w_exp_b    = in_b[W-2:MAN_W];
  assign w_man_a    = in_a[MAN_W-1:0];
  assign w_man_b    = in_b[MAN_W-1:0];
  assign w_nan_a    = (&w_exp_a) & (|w_man_a);
  assign w_nan_b    = (&w_exp_b) & (|w_man_b);
  assign w_zero_a   = ~|in_a[W-2:0];
  assign w_zero_b   = ~|in_b[W-2:0];
  assign w_c_unord  = w_nan_a | w_nan_b;
  assign w_c_eq_raw = (in_a == in_b) | (w_zero_a & w_zero_b);
  assign w_c_mag_lt = in_a[W-2:0] < in_b[W-2:0];
  assign w_c_sa     = in_a[W-1];
  assign w_c_sb     = in_b[W-1];

  // Sign-magnitude ordering: with both negative, the larger magnitude is the smaller value.
  function automatic logic resolve(input logic [2:0] op, input logic unord,
                                   input logic eq_raw, input logic mag_lt,
                                   input logic sa, input logic sb);
    logic lt;
    logic eq;
    lt = ~unord & ~eq_raw &
         ((sa & ~sb) | (~sa & ~sb & mag_lt) | (sa & sb & ~mag_lt));
    eq = ~unord & eq_raw;
    case (op)
      3'b000:  return eq;
      3'b001:  return ~eq;
      3'b100:  return lt;
      3'b101:  return ~unord & ~lt;
      3'b110:  return lt | eq;
      3'b111:  return ~unord & ~lt & ~eq;
      default: return 1'b0;
    endcase
  endfunction

  generate
    if (STAGES == 2) begin : g_two
      logic                 r_v1, r_unord1, r_eq1, r_lt1, r_sa1, r_sb1;
      logic [2:0]           r_op1;
      logic [TAG_W-1:0]     r_tag1;
      logic                 r_v2, r_res2, r_unord2;
      logic [TAG_W-1:0]     r_tag2;
      logic                 w_adv1, w_adv2;

      assign w_adv2   = ~r_v2 | out_ready;
      assign w_adv1   = ~r_v1 | w_adv2;
      assign in_ready = w_adv1 & ~flush;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_v1     <= 1'b0;
          r_op1    <= '0;
          r_unord1 <= 1'b0;
          r_eq1    <= 1'b0;
          r_lt1    <= 1'b0;
          r_sa1    <= 1'b0;
          r_sb1    <= 1'b0;
          r_tag1   <= '0;
        end else if (flush) begin
          r_v1 <= 1'b0;
        end else if (w_adv1) begin
          r_v1 <= in_valid;
          if (in_valid) begin
            r_op1    <= in_op;
            r_unord1 <= w_c_unord;
            r_eq1    <= w_c_eq_raw;
            r_lt1    <= w_c_mag_lt;
            r_sa1    <= w_c_sa;
            r_sb1    <= w_c_sb;
            r_tag1   <= in_tag;
          end
        end
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_v2     <= 1'b0;
          r_res2   <= 1'b0;
          r_unord2 <= 1'b0;
          r_tag2   <= '0;
        end else if (flush) begin
          r_v2 <= 1'b0;
        end else if (w_adv2) begin
          r_v2 <= r_v1;
          if (r_v1) begin
            r_res2   <= resolve(r_op1, r_unord1, r_eq1, r_lt1, r_sa1, r_sb1);
            r_unord2 <= r_unord1;
            r_tag2   <= r_tag1;
          end
        end
      end

      assign out_valid = r_v2;
      assign out_res   = r_res2;
      assign out_unord = r_unord2;
      assign out_tag   = r_tag2;
    end else if (STAGES == 1) begin : g_one
      logic             r_v, r_res, r_unord;
      logic [TAG_W-1:0] r_tag;
      logic             w_adv;

      assign w_adv    = ~r_v | out_ready;
      assign in_ready = w_adv & ~flush;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_v     <= 1'b0;
          r_res   <= 1'b0;
          r_unord <= 1'b0;
          r_tag   <= '0;
        end else if (flush) begin
          r_v <= 1'b0;
        end else if (w_adv) begin
          r_v <= in_valid;
          if (in_valid) begin
            r_res   <= resolve(in_op, w_c_unord, w_c_eq_raw, w_c_mag_lt, w_c_sa, w_c_sb);
            r_unord <= w_c_unord;
            r_tag   <= in_tag;
          end
        end
      end

      assign out_valid = r_v;
      assign out_res   = r_res;
      assign out_unord = r_unord;
      assign out_tag   = r_tag;
    end else begin : g_bad
      $error("fcmp_pipe: STAGES must be 1 or 2");
      assign in_ready  = 1'b0;
      assign out_valid = 1'b0;
      assign out_res   = 1'b0;
      assign out_unord = 1'b0;
      assign out_tag   = '0;
    end
  endgenerate

endmodule

// File: tb/tb_fcmp_pipe.sv
// Bench for fcmp_pipe: a 32-bit two-stage instance under random traffic with a queue
// scoreboard, and a 64-bit single-stage instance driven one op at a time.
module tb_fcmp_pipe;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        in_valid, in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_tag;
  logic        out_valid, out_ready, out_res, out_unord;
  logic [4:0]  out_tag;

  logic        d_in_valid, d_in_ready;
  logic [2:0]  d_in_op;
  logic [63:0] d_in_a, d_in_b;
  logic [4:0]  d_in_tag;
  logic        d_out_valid, d_out_ready, d_out_res, d_out_unord;
  logic [4:0]  d_out_tag;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int n_pops  = 0;
  int ready_mode = 0;
  logic [6:0] exp_q[$];

  fcmp_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(2), .TAG_W(5)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_unord(out_unord), .out_tag(out_tag)
  );

  fcmp_pipe #(.EXP_W(11), .MAN_W(52), .STAGES(1), .TAG_W(5)) dut64 (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_op(d_in_op),
    .in_a(d_in_a), .in_b(d_in_b), .in_tag(d_in_tag),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_res(d_out_res),
    .out_unord(d_out_unord), .out_tag(d_out_tag)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (ready_mode == 1) out_ready = 1'b1;
    else if (ready_mode == 2) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference: IEEE order on a signed integer key (sign applied to the magnitude field),
  // which places -0 and +0 together and orders denormals and infinities naturally.
  function automatic logic [1:0] ref_cmp(input logic [2:0] op, input logic [63:0] a,
                                         input logic [63:0] b, input int ew, input int mw);
    int w;
    logic [63:0] mag_mask, emask, mmask;
    longint ka, kb;
    logic nan_a, nan_b, un, r;
    w        = 1 + ew + mw;
    mag_mask = (64'd1 << (w - 1)) - 64'd1;
    emask    = (64'd1 << ew) - 64'd1;
    mmask    = (64'd1 << mw) - 64'd1;
    nan_a    = (((a >> mw) & emask) == emask) && ((a & mmask) != 64'd0);
    nan_b    = (((b >> mw) & emask) == emask) && ((b & mmask) != 64'd0);
    ka       = a[w-1] ? -longint'(a & mag_mask) : longint'(a & mag_mask);
    kb       = b[w-1] ? -longint'(b & mag_mask) : longint'(b & mag_mask);
    un       = nan_a | nan_b;
    case (op)
      3'd0:    r = !un && (ka == kb);
      3'd1:    r = un || (ka != kb);
      3'd4:    r = !un && (ka < kb);
      3'd5:    r = !un && (ka >= kb);
      3'd6:    r = !un && (ka <= kb);
      3'd7:    r = !un && (ka > kb);
      default: r = 1'b0;
    endcase
    return {r, un};
  endfunction

  // Scoreboard for the 32-bit instance; every valid cycle must show the queue head.
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
        else begin
          chk("sb_res_unord_tag", 64'({out_res, out_unord, out_tag}), 64'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_pops++;
          end
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back({ref_cmp(in_op, 64'(in_a), 64'(in_b), 8, 23), in_tag});
      if (flush) exp_q.delete();
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag);
    int n;
    logic fired;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    n = 0; fired = 1'b0;
    while (!fired && n < 100) begin
      @(negedge clk);
      fired = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!fired) chk("send_timeout", 64'd1, 64'd0);
  endtask

  task automatic run_one(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, output logic res, output logic unord);
    int n;
    send(op, a, b, tag);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 20);
    if (!out_valid) chk("run_one_timeout", 64'd1, 64'd0);
    res = out_res;
    unord = out_unord;
    @(posedge clk); #1;
  endtask

  task automatic send64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] tag, output logic res);
    int n, t0;
    logic [1:0] m;
    d_in_valid = 1'b1; d_in_op = op; d_in_a = a; d_in_b = b; d_in_tag = tag;
    n = 0;
    do begin @(negedge clk); n++; end while (!d_in_ready && n < 20);
    if (!d_in_ready) chk("d64_in_timeout", 64'd1, 64'd0);
    t0 = cyc;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!d_out_valid && n < 20);
    chk("d64_lat", 64'(cyc - t0), 64'd1);
    m = ref_cmp(op, a, b, 11, 52);
    chk("d64_res_unord_tag", 64'({d_out_res, d_out_unord, d_out_tag}), 64'({m, tag}));
    res = d_out_res;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("drain_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_op32();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: begin
        case ($urandom_range(0, 7))
          0: v = 32'h0000_0000;
          1: v = 32'h8000_0000;
          2: v = 32'h7F80_0000;
          3: v = 32'hFF80_0000;
          4: v = 32'h7FC0_0000;
          5: v = 32'h7F80_0001;
          6: v = 32'h3F80_0000;
          default: v = 32'hBF80_0000;
        endcase
      end
      1: v = $urandom();
      2: v = {1'($urandom_range(0, 1)), 8'd0, 23'($urandom_range(0, 15))};
      default: v = {1'($urandom_range(0, 1)), 8'($urandom_range(125, 129)),
                    23'($urandom_range(0, 3))};
    endcase
    return v;
  endfunction

  function automatic logic [63:0] rand_op64();
    logic [63:0] v;
    case ($urandom_range(0, 3))
      0: v = {$urandom(), $urandom()};
      1: v = {1'($urandom_range(0, 1)), 11'd0, 52'($urandom_range(0, 7))};
      2: v = {1'($urandom_range(0, 1)), 11'h7FF, 52'($urandom_range(0, 2))};
      default: v = {1'($urandom_range(0, 1)), 11'($urandom_range(1022, 1024)),
                    52'($urandom_range(0, 3))};
    endcase
    return v;
  endfunction

  // ---------------- sequence ----------------
  initial begin
    logic r, u;
    logic [31:0] a, b;
    logic [63:0] da, db;
    int n0;

    rstn = 1'b0; flush = 1'b0; out_ready = 1'b1; d_out_ready = 1'b1;
    in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    d_in_valid = 1'b0; d_in_op = '0; d_in_a = '0; d_in_b = '0; d_in_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_res", 64'(out_res), 64'd0);
    chk("rst_out_unord", 64'(out_unord), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_d64_out_valid", 64'(d_out_valid), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // directed vectors
    ready_mode = 1; out_ready = 1'b1;
    run_one(3'b000, 32'h0000_0000, 32'h8000_0000, 5'd1, r, u);
    chk("eq_pz_nz_res", 64'(r), 64'd1);
    chk("eq_pz_nz_unord", 64'(u), 64'd0);
    run_one(3'b100, 32'h0000_0000, 32'h8000_0000, 5'd2, r, u);
    chk("lt_pz_nz", 64'(r), 64'd0);
    run_one(3'b100, 32'h8000_0000, 32'h0000_0000, 5'd3, r, u);
    chk("lt_nz_pz", 64'(r), 64'd0);
    run_one(3'b100, 32'hBF80_0000, 32'hC000_0000, 5'd4, r, u);
    chk("lt_m1_m2", 64'(r), 64'd0);
    run_one(3'b111, 32'hBF80_0000, 32'hC000_0000, 5'd5, r, u);
    chk("gt_m1_m2", 64'(r), 64'd1);
    run_one(3'b110, 32'h3F80_0000, 32'h3F80_0000, 5'd6, r, u);
    chk("le_eq_one", 64'(r), 64'd1);
    run_one(3'b101, 32'h7FC0_0000, 32'h3F80_0000, 5'd7, r, u);
    chk("ge_qnan_res", 64'(r), 64'd0);
    chk("ge_qnan_unord", 64'(u), 64'd1);
    run_one(3'b001, 32'h7FC0_0000, 32'h3F80_0000, 5'd8, r, u);
    chk("ne_qnan_res", 64'(r), 64'd1);
    run_one(3'b010, 32'h7F80_0001, 32'h3F80_0000, 5'd9, r, u);
    chk("rsv_snan_res", 64'(r), 64'd0);
    chk("rsv_snan_unord", 64'(u), 64'd1);
    run_one(3'b111, 32'h0000_0001, 32'h0000_0000, 5'd10, r, u);
    chk("gt_denorm", 64'(r), 64'd1);

    // back-to-back burst: latency and tag order
    fork
      begin
        for (int i = 0; i < 8; i++) send(3'b100, $urandom(), $urandom(), 5'(i));
      end
      begin
        int t0, n;
        n = 0;
        do begin @(negedge clk); n++; end while (!(in_valid && in_ready) && n < 50);
        t0 = cyc;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 50);
        chk("burst_latency", 64'(cyc - t0), 64'd2);
        for (int i = 0; i < 8; i++) begin
          chk("burst_valid", 64'(out_valid), 64'd1);
          chk("burst_tag", 64'(out_tag), 64'(i));
          if (i < 7) @(negedge clk);
        end
      end
    join
    wait_drain();

    // burst with a 3-cycle output stall
    ready_mode = 0; out_ready = 1'b1;
    n0 = n_pops;
    fork
      begin
        for (int i = 0; i < 8; i++) send(3'($urandom_range(0, 7)), rand_op32(), rand_op32(), 5'(8 + i));
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("stall_burst_count", 64'(n_pops - n0), 64'd8);

    // flush with two ops in flight
    out_ready = 1'b0;
    send(3'b000, 32'h3F80_0000, 32'h3F80_0000, 5'd20);
    send(3'b001, 32'h3F80_0000, 32'h3F80_0000, 5'd21);
    flush = 1'b1;
    in_valid = 1'b1; in_op = 3'b000; in_a = 32'h0; in_b = 32'h0; in_tag = 5'd22;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    ready_mode = 1;
    run_one(3'b000, 32'h3F80_0000, 32'h3F80_0000, 5'd23, r, u);
    chk("post_flush_res", 64'(r), 64'd1);

    // asynchronous reset with the pipe full
    ready_mode = 0; out_ready = 1'b0;
    send(3'b111, 32'h4000_0000, 32'h3F80_0000, 5'd25);
    send(3'b111, 32'h4000_0000, 32'h3F80_0000, 5'd26);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_out_res", 64'(out_res), 64'd0);
    chk("async_rst_out_tag", 64'(out_tag), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // random traffic with random back-pressure
    ready_mode = 2;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      a = rand_op32();
      case ($urandom_range(0, 7))
        0, 1:    b = a;
        2:       b = a ^ 32'h8000_0000;
        default: b = rand_op32();
      endcase
      send(3'($urandom_range(0, 7)), a, b, 5'($urandom_range(0, 31)));
    end
    ready_mode = 1;
    wait_drain();

    // 64-bit single-stage instance
    send64(3'b111, 64'h0000_0000_0000_0001, 64'h0, 5'd1, r);
    chk("d64_gt_denorm", 64'(r), 64'd1);
    send64(3'b000, 64'h0, 64'h8000_0000_0000_0000, 5'd2, r);
    chk("d64_eq_zeros", 64'(r), 64'd1);
    for (int i = 0; i < 40; i++) begin
      da = rand_op64();
      db = ($urandom_range(0, 3) == 0) ? da : rand_op64();
      send64(3'($urandom_range(0, 7)), da, db, 5'(i), r);
    end

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
